// File: rtl/ip_ram_arbiter_pkg.sv
// rtl/ip_ram_arbiter_pkg.sv - shared widths, master ids and command-stage type for the RAM arbiter
package ip_ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [ADDR_W_DEF-1:0] address;
    logic [DATA_W_DEF-1:0] wdata;
    logic                  id;
  } cmd_stage_t;

  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/ip_ram_arbiter_rr.sv
// rtl/ip_ram_arbiter_rr.sv - round-robin grant with bounded hold between the two masters
module ip_ram_arbiter_rr
  import ip_ram_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       accept,
  output logic [1:0] grant
);

  localparam logic [3:0] HOLD_L = 4'(HOLD_MAX);

  logic       last_grant;
  logic [3:0] hold_cnt;
  logic       gid;
  logic       keep;

  // A zero hold count means no streak in progress, so contention alternates.
  assign keep = (hold_cnt != 4'd0) && (hold_cnt < HOLD_L);

  always_comb begin
    gid = M0;
    if (req0 && req1) begin
      gid = keep ? last_grant : other_id(last_grant);
    end else if (req1) begin
      gid = M1;
    end
    grant[0] = (req0 || req1) && (gid == M0);
    grant[1] = (req0 || req1) && (gid == M1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= M1;
      hold_cnt   <= 4'd0;
    end else if (accept) begin
      last_grant <= gid;
      if (gid == last_grant) begin
        hold_cnt <= (hold_cnt == HOLD_L) ? hold_cnt : hold_cnt + 4'd1;
      end else begin
        hold_cnt <= 4'd1;
      end
    end else begin
      hold_cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/ip_ram_arbiter.sv
// rtl/ip_ram_arbiter.sv - two-master arbiter, command stage and tagged read return for the logger RAM
// Optional statistics counters are built when IP_RAM_ARBITER_STATS_EN is defined.
module ip_ram_arbiter
  import ip_ram_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rdata_en,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rdata_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_valid,
  input  logic              ram_ready,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_rdata_en,
  output logic [15:0]       stat_m0_cnt,
  output logic [15:0]       stat_m1_cnt,
  output logic [15:0]       stat_conflict_cnt
);

  cmd_stage_t stage;
  logic [1:0] grant;
  logic       stage_free;
  logic       accept;
  logic       accept_id;
  logic       rd_issue;
  logic       tag_valid;
  logic       tag_id;

  assign stage_free = !stage.valid || ram_ready;
  assign m0_ready   = grant[0] && stage_free && !reset;
  assign m1_ready   = grant[1] && stage_free && !reset;
  assign accept     = (m0_valid && m0_ready) || (m1_valid && m1_ready);
  assign accept_id  = grant[1] ? M1 : M0;
  assign rd_issue   = stage.valid && ram_ready && !stage.write;

  ip_ram_arbiter_rr #(.HOLD_MAX(HOLD_MAX)) u_rr (
    .clk    (clk),
    .reset  (reset),
    .req0   (m0_valid),
    .req1   (m1_valid),
    .accept (accept),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage     <= '0;
      tag_valid <= 1'b0;
      tag_id    <= M0;
    end else begin
      if (accept) begin
        stage.valid   <= 1'b1;
        stage.write   <= accept_id ? m1_write : m0_write;
        stage.address <= accept_id ? m1_address : m0_address;
        stage.wdata   <= accept_id ? m1_wdata : m0_wdata;
        stage.id      <= accept_id;
      end else if (stage_free) begin
        stage.valid <= 1'b0;
      end
      // The tag follows each issued read by exactly one cycle, matching the RAM latency.
      tag_valid <= rd_issue;
      if (rd_issue) begin
        tag_id <= stage.id;
      end
    end
  end

  assign ram_valid   = stage.valid;
  assign ram_write   = stage.write;
  assign ram_address = stage.address;
  assign ram_wdata   = stage.wdata;

  assign m0_rdata_en = ram_rdata_en && tag_valid && (tag_id == M0);
  assign m1_rdata_en = ram_rdata_en && tag_valid && (tag_id == M1);
  assign m0_rdata    = m0_rdata_en ? ram_rdata : '0;
  assign m1_rdata    = m1_rdata_en ? ram_rdata : '0;

`ifdef IP_RAM_ARBITER_STATS_EN
  logic [15:0] m0_cnt;
  logic [15:0] m1_cnt;
  logic [15:0] conflict_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_cnt       <= 16'd0;
      m1_cnt       <= 16'd0;
      conflict_cnt <= 16'd0;
    end else begin
      if (m0_valid && m0_ready && m0_cnt != 16'hFFFF) m0_cnt <= m0_cnt + 16'd1;
      if (m1_valid && m1_ready && m1_cnt != 16'hFFFF) m1_cnt <= m1_cnt + 16'd1;
      if (m0_valid && m1_valid && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  assign stat_m0_cnt       = m0_cnt;
  assign stat_m1_cnt       = m1_cnt;
  assign stat_conflict_cnt = conflict_cnt;
`else
  assign stat_m0_cnt       = 16'd0;
  assign stat_m1_cnt       = 16'd0;
  assign stat_conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ip_ram_arbiter.sv
// tb/tb_ip_ram_arbiter.sv - directed plus randomized check of ip_ram_arbiter against a transaction-level model
module tb_ip_ram_arbiter;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] m0_address, m1_address, ram_address;
  logic        m0_valid, m0_ready, m0_write, m0_rdata_en;
  logic        m1_valid, m1_ready, m1_write, m1_rdata_en;
  logic [31:0] m0_wdata, m0_rdata, m1_wdata, m1_rdata;
  logic        ram_valid, ram_ready, ram_write, ram_rdata_en;
  logic [31:0] ram_wdata, ram_rdata;
  logic [15:0] stat_m0_cnt, stat_m1_cnt, stat_conflict_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem    [4096];
  logic [31:0] shadow [4096];

  bit          p_v [2];
  bit          p_w [2];
  logic [11:0] p_a [2];
  logic [31:0] p_d [2];
  bit          acc_n [2];

  bit          st_full, st_wr, st_id;
  logic [11:0] st_addr;
  logic [31:0] st_wd, st_rd;
  bit          ret_pending, ret_id;
  logic [31:0] ret_data;
  int          last_g, streak;
  bit          inject;
  int          obs_q [$];

  ip_ram_arbiter #(.HOLD_MAX(HOLD), .ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write(m0_write),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_rdata_en(m0_rdata_en),
    .m1_address(m1_address), .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write(m1_write),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_rdata_en(m1_rdata_en),
    .ram_address(ram_address), .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_write(ram_write),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_rdata_en(ram_rdata_en),
    .stat_m0_cnt(stat_m0_cnt), .stat_m1_cnt(stat_m1_cnt), .stat_conflict_cnt(stat_conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    m0_valid = p_v[0]; m0_write = p_w[0]; m0_address = p_a[0]; m0_wdata = p_d[0];
    m1_valid = p_v[1]; m1_write = p_w[1]; m1_address = p_a[1]; m1_wdata = p_d[1];
  endtask

  task automatic new_cmd(input int n, input bit w, input logic [11:0] a, input logic [31:0] d);
    p_v[n] = 1'b1; p_w[n] = w; p_a[n] = a; p_d[n] = d;
  endtask

  // One clock: entered at a falling edge with inputs set, left at the next falling edge.
  task automatic step();
    int          g;
    bit          free, acc, rd_next;
    logic [31:0] rd_data;
    #1;
    chk("ram_valid", ram_valid, st_full);
    if (st_full) begin
      chk("ram_write", ram_write, st_wr);
      chk("ram_address", ram_address, st_addr);
      chk("ram_wdata", ram_wdata, st_wd);
    end
    chk("m0_rdata_en", m0_rdata_en, ret_pending && !ret_id);
    chk("m0_rdata", m0_rdata, (ret_pending && !ret_id) ? ret_data : 32'h0);
    chk("m1_rdata_en", m1_rdata_en, ret_pending && ret_id);
    chk("m1_rdata", m1_rdata, (ret_pending && ret_id) ? ret_data : 32'h0);

    g = -1;
    if (p_v[0] && p_v[1]) g = (streak > 0 && streak < HOLD) ? last_g : 1 - last_g;
    else if (p_v[0]) g = 0;
    else if (p_v[1]) g = 1;
    free = !st_full || ram_ready;
    chk("m0_ready", m0_ready, (g == 0) && free);
    chk("m1_ready", m1_ready, (g == 1) && free);
    acc = (g >= 0) && free;
    if (m1_valid && m1_ready) obs_q.push_back(1);
    else if (m0_valid && m0_ready) obs_q.push_back(0);

    rd_next = 1'b0;
    rd_data = 32'h0;
    if (ram_valid && ram_ready) begin
      if (ram_write) mem[ram_address] = ram_wdata;
      else begin
        rd_next = 1'b1;
        rd_data = mem[ram_address];
      end
    end

    ret_pending = st_full && ram_ready && !st_wr;
    ret_id      = st_id;
    ret_data    = st_rd;
    if (acc) begin
      st_full = 1'b1;
      st_wr   = p_w[g];
      st_id   = (g == 1);
      st_addr = p_a[g];
      st_wd   = p_d[g];
      st_rd   = shadow[p_a[g]];
      if (p_w[g]) shadow[p_a[g]] = p_d[g];
      streak  = (g == last_g) ? ((streak < HOLD) ? streak + 1 : HOLD) : 1;
      last_g  = g;
    end else begin
      if (st_full && ram_ready) st_full = 1'b0;
      streak = 0;
    end
    acc_n[0] = acc && (g == 0);
    acc_n[1] = acc && (g == 1);

    @(posedge clk);
    #1;
    ram_rdata_en = rd_next || inject;
    ram_rdata    = rd_next ? rd_data : $urandom();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ram_valid", ram_valid, 1'b0);
    chk("rst_ram_write", ram_write, 1'b0);
    chk("rst_ram_address", ram_address, 12'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_m0_ready", m0_ready, 1'b0);
    chk("rst_m1_ready", m1_ready, 1'b0);
    chk("rst_m0_rdata_en", m0_rdata_en, 1'b0);
    chk("rst_m1_rdata_en", m1_rdata_en, 1'b0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_stat_m0", stat_m0_cnt, 16'h0);
    chk("rst_stat_m1", stat_m1_cnt, 16'h0);
    chk("rst_stat_conflict", stat_conflict_cnt, 16'h0);
    @(posedge clk);
    #1;
    ram_rdata_en = 1'b0;
    inject = 1'b0;
    @(negedge clk);
    chk("rst_hold_m0_ready", m0_ready, 1'b0);
    reset = 1'b0;
    st_full = 1'b0; ret_pending = 1'b0; last_g = 1; streak = 0;
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    apply();
  endtask

  initial begin
    reset = 1'b1; ram_ready = 1'b1; ram_rdata_en = 1'b0; ram_rdata = 32'h0; inject = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_v[i] = 1'b0; p_w[i] = 1'b0; p_a[i] = 12'h0; p_d[i] = 32'h0;
    end
    apply();
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = 32'hA5000000 ^ (i * 32'h00010003);
      shadow[i] = 32'hA5000000 ^ (i * 32'h00010003);
    end
    mem[5] = 32'hDEADBEEF;
    shadow[5] = 32'hDEADBEEF;
    st_full = 1'b0; st_wr = 1'b0; st_id = 1'b0; st_addr = 12'h0; st_wd = 32'h0; st_rd = 32'h0;
    ret_pending = 1'b0; ret_id = 1'b0; ret_data = 32'h0; last_g = 1; streak = 0;
    @(negedge clk);
    do_reset();

    // Single m1 read of a preloaded word
    new_cmd(1, 1'b0, 12'h005, 32'h0);
    apply();
    step();
    p_v[1] = 1'b0;
    apply();
    step();
    chk("m1_read_en", m1_rdata_en, 1'b1);
    chk("m1_read_data", m1_rdata, 32'hDEADBEEF);
    chk("m1_read_m0_quiet", m0_rdata_en, 1'b0);
    step();

    // Write at the top address, then read it back from the other master
    new_cmd(0, 1'b1, 12'hFFF, 32'h12345678);
    apply();
    step();
    p_v[0] = 1'b0;
    new_cmd(1, 1'b0, 12'hFFF, 32'h0);
    apply();
    step();
    p_v[1] = 1'b0;
    apply();
    step();
    chk("wr_rd_fff_en", m1_rdata_en, 1'b1);
    chk("wr_rd_fff_data", m1_rdata, 32'h12345678);
    step();

    // Continuous contention from a fresh reset
    do_reset();
    obs_q.delete();
    new_cmd(0, 1'b0, 12'($urandom_range(0, 4095)), 32'h0);
    new_cmd(1, 1'b0, 12'($urandom_range(0, 4095)), 32'h0);
    apply();
    for (int c = 0; c < 24; c++) begin
      step();
      for (int n = 0; n < 2; n++)
        if (acc_n[n]) new_cmd(n, 1'b0, 12'($urandom_range(0, 4095)), 32'h0);
      apply();
    end
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    apply();
    step();
    step();
    chk("rr_count", obs_q.size(), 24);
    for (int i = 0; i < 24 && i < obs_q.size(); i++)
      chk("rr_pattern", obs_q[i], (i / HOLD) % 2);

    // RAM stall while the stage holds a read
    new_cmd(0, 1'b0, 12'h033, 32'h0);
    apply();
    step();
    new_cmd(0, 1'b0, 12'h034, 32'h0);
    new_cmd(1, 1'b0, 12'h035, 32'h0);
    ram_ready = 1'b0;
    apply();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_address", ram_address, 12'h033);
    end
    ram_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      for (int n = 0; n < 2; n++) if (acc_n[n]) p_v[n] = 1'b0;
      apply();
    end

    // Reset the cycle after a read is accepted
    new_cmd(0, 1'b0, 12'h010, 32'h0);
    new_cmd(1, 1'b0, 12'h011, 32'h0);
    apply();
    step();
    do_reset();
    new_cmd(0, 1'b0, 12'h012, 32'h0);
    new_cmd(1, 1'b0, 12'h013, 32'h0);
    apply();
    #1;
    chk("post_rst_m0_ready", m0_ready, 1'b1);
    chk("post_rst_m1_ready", m1_ready, 1'b0);
    step();
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    apply();
    step();

    // Randomized traffic with RAM back-pressure and stray return strobes
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!p_v[n] || acc_n[n]) begin
          p_v[n] = ($urandom_range(0, 3) != 0);
          p_w[n] = ($urandom_range(0, 2) == 0);
          p_a[n] = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 7));
          p_d[n] = $urandom();
        end
      end
      ram_ready = ($urandom_range(0, 3) != 0);
      inject = ($urandom_range(0, 9) == 0);
      apply();
      step();
    end
    inject = 1'b0;
    ram_ready = 1'b1;
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    apply();
    step();
    step();

    // Statistics: 8 contention cycles, then 6 solo m0 beats and 2 solo m1 beats
    do_reset();
    new_cmd(0, 1'b1, 12'h100, $urandom());
    new_cmd(1, 1'b1, 12'h200, $urandom());
    apply();
    for (int c = 0; c < 8; c++) begin
      step();
      for (int n = 0; n < 2; n++) if (acc_n[n]) new_cmd(n, 1'b1, 12'(c + 16 * n), $urandom());
      apply();
    end
    p_v[1] = 1'b0;
    apply();
    for (int c = 0; c < 6; c++) begin
      step();
      if (acc_n[0]) new_cmd(0, 1'b1, 12'(c + 32), $urandom());
      apply();
    end
    p_v[0] = 1'b0;
    new_cmd(1, 1'b1, 12'h040, $urandom());
    apply();
    for (int c = 0; c < 2; c++) begin
      step();
      if (acc_n[1]) new_cmd(1, 1'b1, 12'(c + 48), $urandom());
      apply();
    end
    p_v[1] = 1'b0;
    apply();
    step();
`ifdef IP_RAM_ARBITER_STATS_EN
    chk("stat_m0", stat_m0_cnt, 16'd10);
    chk("stat_m1", stat_m1_cnt, 16'd6);
    chk("stat_conflict", stat_conflict_cnt, 16'd8);
`else
    chk("stat_m0", stat_m0_cnt, 16'd0);
    chk("stat_m1", stat_m1_cnt, 16'd0);
    chk("stat_conflict", stat_conflict_cnt, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
